// File: rtl/ps2_key_event_sequencer.sv
// ps2_key_event_sequencer: parses PS/2 bytes (E0/F0 prefixes) into {ext,release,code} events queued in a FIFO.
// Optional typematic repeat suppression when PS2_REPEAT_FILTER_EN is defined.
module ps2_key_event_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              inclock,
  input  logic              resetn,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_ext,
  output logic              evt_release,
  output logic [7:0]        evt_code,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              proto_err
);
  localparam logic [1:0] IDLE = 2'd0, GOT_E0 = 2'd1, GOT_F0 = 2'd2, GOT_E0F0 = 2'd3;
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [1:0] state, state_nxt;
  logic [CW-1:0] cnt;
  logic is_status, timeout, push_raw, push, ev_ext, ev_rel, err;
  logic [9:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0] wr, rd;
  logic full, pop, wr_en, drop;
  assign is_status = byte_data inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  assign timeout = (state != IDLE) && !byte_valid && (cnt == CW'(TIMEOUT_CYC - 1));
  always_comb begin
    state_nxt = state;
    push_raw = 1'b0;
    ev_ext = 1'b0;
    ev_rel = 1'b0;
    err = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      err = 1'b1;
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == 8'hE0) state_nxt = GOT_E0;
          else if (byte_data == 8'hF0) state_nxt = GOT_F0;
          else push_raw = !is_status;
        end
        GOT_E0: begin
          if (byte_data == 8'hF0) state_nxt = GOT_E0F0;
          else if (byte_data != 8'hE0) begin
            state_nxt = IDLE;
            push_raw = !is_status;
            ev_ext = 1'b1;
          end
        end
        GOT_F0: begin
          if (byte_data == 8'hF0) err = 1'b1;
          else if (byte_data == 8'hE0) state_nxt = GOT_E0F0;
          else begin
            state_nxt = IDLE;
            push_raw = 1'b1;
            ev_rel = 1'b1;
          end
        end
        default: begin
          if (byte_data == 8'hF0) err = 1'b1;
          else begin
            state_nxt = IDLE;
            push_raw = 1'b1;
            ev_ext = 1'b1;
            ev_rel = 1'b1;
          end
        end
      endcase
    end
  end
`ifdef PS2_REPEAT_FILTER_EN
  logic held_vld, held_ext, match;
  logic [7:0] held_code;
  assign match = held_vld && (held_ext == ev_ext) && (held_code == byte_data);
  assign push = push_raw && (ev_rel || !match);
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      held_vld <= 1'b0;
      held_ext <= 1'b0;
      held_code <= 8'h00;
    end else if (push_raw && !ev_rel && !match) begin
      held_vld <= 1'b1;
      held_ext <= ev_ext;
      held_code <= byte_data;
    end else if (push_raw && ev_rel && match) begin
      held_vld <= 1'b0;
    end
  end
`else
  assign push = push_raw;
`endif
  assign fifo_count = wr - rd;
  assign evt_valid = wr != rd;
  assign full = fifo_count == (ADDR_W + 1)'(FIFO_DEPTH);
  assign pop = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign drop = push && full && !pop;
  assign {evt_ext, evt_release, evt_code} = evt_valid ? mem[rd[ADDR_W-1:0]] : 10'd0;
  always_ff @(posedge inclock) begin
    if (wr_en) mem[wr[ADDR_W-1:0]] <= {ev_ext, ev_rel, byte_data};
  end
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      wr <= '0;
      rd <= '0;
      overflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state_nxt == IDLE || byte_valid || state_nxt != state) ? '0 : cnt + 1'b1;
      wr <= wr_en ? wr + 1'b1 : wr;
      rd <= pop ? rd + 1'b1 : rd;
      overflow <= drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
      proto_err <= err;
    end
  end
endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// tb_ps2_key_event_sequencer: directed and randomized checks against a queue-based model of the event sequencer.
module tb_ps2_key_event_sequencer;
  localparam int D = 8, AW = 3, T = 40;
  logic inclock = 1'b0, resetn = 1'b0, byte_valid = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic evt_valid, evt_ext, evt_release, overflow, proto_err;
  logic [7:0] evt_code;
  logic [AW:0] fifo_count;
  int n_vec = 0, n_err = 0, obs_err = 0, exp_err = 0, idle = 0;
  logic [9:0] q[$];
  bit exp_ovf = 0, m_ext = 0, m_rel = 0;
`ifdef PS2_REPEAT_FILTER_EN
  bit h_vld = 0, h_ext = 0;
  logic [7:0] h_code = 8'h00;
`endif

  ps2_key_event_sequencer #(.FIFO_DEPTH(D), .ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
    .inclock(inclock), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ext(evt_ext), .evt_release(evt_release),
    .evt_code(evt_code), .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr),
    .proto_err(proto_err));

  always #5 inclock = ~inclock;
  always @(posedge inclock) if (proto_err === 1'b1) obs_err++;

  function automatic bit is_status(input logic [7:0] b);
    return b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic emit(input bit e, input bit r, input logic [7:0] c, output bit push);
    push = 1;
`ifdef PS2_REPEAT_FILTER_EN
    if (!r) begin
      if (h_vld && h_ext == e && h_code == c) push = 0;
      else begin h_vld = 1; h_ext = e; h_code = c; end
    end else if (h_vld && h_ext == e && h_code == c) h_vld = 0;
`else
    if (c === 8'hxx && e && r) push = 1;
`endif
  endtask

  // Prefix grammar: a key event is [E0] [F0] code; status bytes outside a break are ignored.
  task automatic parse(input logic [7:0] b, output bit push, output logic [9:0] ev);
    bit e = m_ext, r = m_rel;
    push = 0;
    ev = {e, r, b};
    if (!e && !r) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else if (!is_status(b)) emit(0, 0, b, push);
    end else if (e && !r) begin
      if (b == 8'hF0) m_rel = 1;
      else if (b != 8'hE0) begin
        if (!is_status(b)) emit(1, 0, b, push);
        m_ext = 0;
      end
    end else if (b == 8'hF0) exp_err++;
    else if (!e && b == 8'hE0) m_ext = 1;
    else begin
      emit(e, 1, b, push);
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  task automatic step(input bit bv, input logic [7:0] b, input bit rdy, input bit clr);
    bit push = 0, pop, drop;
    logic [9:0] ev = 10'd0;
    byte_valid = bv; byte_data = b; evt_ready = rdy; ovf_clr = clr;
    pop = rdy && q.size() != 0;
    if (bv) begin
      parse(b, push, ev);
      idle = 0;
    end else if (m_ext || m_rel) begin
      idle++;
      if (idle == T) begin m_ext = 0; m_rel = 0; idle = 0; exp_err++; end
    end else idle = 0;
    drop = push && q.size() == D && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(ev);
    if (drop) exp_ovf = 1;
    else if (clr) exp_ovf = 0;
    @(negedge inclock);
    byte_valid = 0; evt_ready = 0; ovf_clr = 0;
  endtask

  task automatic model_reset();
    q.delete(); exp_ovf = 0; m_ext = 0; m_rel = 0; idle = 0;
`ifdef PS2_REPEAT_FILTER_EN
    h_vld = 0;
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge inclock);
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", evt_valid); end
    n_vec++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    n_vec++; if ({evt_ext, evt_release, evt_code} !== 10'd0) begin n_err++; $display("FAIL reset_head got %h exp 000", {evt_ext, evt_release, evt_code}); end
    n_vec++; if ({overflow, proto_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {overflow, proto_err}); end
    resetn = 1'b1;
    @(negedge inclock);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [7] = '{8'h1C, 8'hE0, 8'h75, 8'hF0, 8'h1C, 8'hE0, 8'hF0};
    logic [9:0] exp [4] = '{{2'b00, 8'h1C}, {2'b10, 8'h75}, {2'b01, 8'h1C}, {2'b11, 8'h75}};
    int e0 = obs_err;
    foreach (bytes[i]) step(1, bytes[i], 0, 0);
    step(1, 8'h75, 0, 0);
    n_vec++; if (fifo_count !== 4'd4) begin n_err++; $display("FAIL basic_count got %0d exp 4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if ({evt_ext, evt_release, evt_code} !== exp[i]) begin n_err++; $display("FAIL basic_event%0d got %h exp %h", i, {evt_ext, evt_release, evt_code}, exp[i]); end
      step(0, 0, 1, 0);
    end
    n_vec++; if (obs_err !== e0) begin n_err++; $display("FAIL basic_proto_err got %0d pulses exp 0", obs_err - e0); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) step(1, 8'(8'h15 + i), 0, 0);
    n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d exp 8", fifo_count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_vec++; if ({evt_ext, evt_release, evt_code} !== 10'h015) begin n_err++; $display("FAIL ovf_head got %h exp 015", {evt_ext, evt_release, evt_code}); end
    step(0, 0, 0, 1);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if ({evt_valid, evt_code} !== {1'b1, 8'(8'h15 + i)}) begin n_err++; $display("FAIL ovf_drain%0d got %h exp %h", i, {evt_valid, evt_code}, {1'b1, 8'(8'h15 + i)}); end
      step(0, 0, 1, 0);
    end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b exp 0", evt_valid); end
  endtask

  task automatic test_timeout();
    int e0 = obs_err;
    step(1, 8'hE0, 0, 0);
    repeat (T - 1) step(0, 0, 0, 0);
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL timeout_early got %b exp 0", proto_err); end
    step(0, 0, 0, 0);
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL timeout_pulse got %b exp 1", proto_err); end
    step(1, 8'h1C, 0, 0);
    n_vec++; if (obs_err - e0 !== 1) begin n_err++; $display("FAIL timeout_count got %0d exp 1", obs_err - e0); end
    n_vec++; if ({evt_valid, evt_ext, evt_release, evt_code} !== {3'b100, 8'h1C}) begin n_err++; $display("FAIL timeout_next got %h exp 41c", {evt_valid, evt_ext, evt_release, evt_code}); end
    step(0, 0, 1, 0);
  endtask

  task automatic test_status();
    int e0 = obs_err;
    step(1, 8'hAA, 0, 0); step(1, 8'hFA, 1, 0); step(1, 8'hE1, 0, 0);
    n_vec++; if ({evt_valid, fifo_count} !== 5'd0) begin n_err++; $display("FAIL status_empty got %h exp 00", {evt_valid, fifo_count}); end
    step(1, 8'hF0, 0, 0); step(1, 8'hF0, 0, 0); step(1, 8'h2B, 0, 0);
    step(0, 0, 0, 0);
    n_vec++; if (obs_err - e0 !== 1) begin n_err++; $display("FAIL status_f0f0_err got %0d exp 1", obs_err - e0); end
    n_vec++; if ({fifo_count, evt_ext, evt_release, evt_code} !== {4'd1, 2'b01, 8'h2B}) begin n_err++; $display("FAIL status_break got %h exp %h", {fifo_count, evt_ext, evt_release, evt_code}, {4'd1, 2'b01, 8'h2B}); end
    step(0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'h33, 1, 0);
    n_vec++; if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin n_err++; $display("FAIL b2b_full got %h exp 10", {fifo_count, overflow}); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (evt_code !== (i < 7 ? 8'(8'h41 + i) : 8'h33)) begin n_err++; $display("FAIL b2b_drain%0d got %h exp %h", i, evt_code, (i < 7 ? 8'(8'h41 + i) : 8'h33)); end
      step(0, 0, 1, 0);
    end
    step(1, 8'h11, 0, 0); step(1, 8'hE0, 0, 0); step(1, 8'hF0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    n_vec++; if ({evt_valid, fifo_count} !== 5'd0) begin n_err++; $display("FAIL async_reset got %h exp 00", {evt_valid, fifo_count}); end
    model_reset();
    @(negedge inclock);
    resetn = 1'b1;
    @(negedge inclock);
    step(1, 8'h75, 0, 0);
    n_vec++; if ({evt_ext, evt_release, evt_code} !== {2'b00, 8'h75}) begin n_err++; $display("FAIL reset_prefix_lost got %h exp 075", {evt_ext, evt_release, evt_code}); end
    step(0, 0, 1, 0);
  endtask

  task automatic test_repeat();
    logic [7:0] bytes [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_REPEAT_FILTER_EN
    logic [9:0] exp [3] = '{10'h01C, 10'h11C, 10'h01C};
`else
    logic [9:0] exp [5] = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
    foreach (bytes[i]) step(1, bytes[i], 0, 0);
    n_vec++; if (fifo_count !== ($bits(fifo_count))'($size(exp))) begin n_err++; $display("FAIL repeat_count got %0d exp %0d", fifo_count, $size(exp)); end
    foreach (exp[i]) begin
      n_vec++; if ({evt_ext, evt_release, evt_code} !== exp[i]) begin n_err++; $display("FAIL repeat_event%0d got %h exp %h", i, {evt_ext, evt_release, evt_code}, exp[i]); end
      step(0, 0, 1, 0);
    end
  endtask

  task automatic test_random();
    logic [7:0] st [7] = '{8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    logic [7:0] b;
    int r;
    for (int c = 0; c < 600; c++) begin
      n_vec++; if (evt_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c%0d got %b exp %b", c, evt_valid, q.size() != 0); end
      n_vec++; if (fifo_count !== ($bits(fifo_count))'(q.size())) begin n_err++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, fifo_count, q.size()); end
      n_vec++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf c%0d got %b exp %b", c, overflow, exp_ovf); end
      if (q.size() != 0) begin
        n_vec++; if ({evt_ext, evt_release, evt_code} !== q[0]) begin n_err++; $display("FAIL rnd_head c%0d got %h exp %h", c, {evt_ext, evt_release, evt_code}, q[0]); end
      end
      r = $urandom_range(99);
      b = r < 20 ? 8'hE0 : r < 35 ? 8'hF0 : r < 45 ? st[$urandom_range(6)] : 8'($urandom_range(8'h7F, 8'h01));
      step($urandom_range(1) == 1, b, $urandom_range(9) < 3, $urandom_range(19) == 0);
    end
    step(1, 8'h1C, 0, 0);
    step(0, 0, 0, 0);
    n_vec++; if (obs_err !== exp_err) begin n_err++; $display("FAIL rnd_proto_err got %0d exp %0d", obs_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_timeout();
    test_status();
    test_back_to_back();
    test_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
